// File: rtl/seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_sched
// Brief    : Round-robin scheduler sharing one serial sequence detector among
//            N_REQ requesters. The granted word is shifted MSB-first into the
//            detector and the detector pulses are counted and returned.
// Options  : SEQ_DET_SCHED_PROT_EN - enables the sticky back-to-back pulse
//            checker on err (err tied low otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_sched #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [CNT_W-1:0]          cnt,
    output logic                      busy,
    output logic                      det_rst,
    output logic                      det_ip,
    input  logic                      det_op,
    output logic                      err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] C_LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] C_LAST_INIT = IDX_W'(N_REQ - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [IDX_W-1:0]  r_last;
    logic [N_REQ-1:0]  r_gnt;
    logic [DATA_W-1:0] r_sreg;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [CNT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    int                w_idx;
    logic              w_sample;
    logic [CNT_W-1:0]  w_acc_next;

    // Round-robin search starting one past the last winner
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = (int'(r_last) + i) % N_REQ;
            if (!w_found && req[IDX_W'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(w_idx);
            end
        end
    end

    // Detector output for bit k lands one cycle later, so the window starts at
    // the second SHIFT cycle and closes after DRAIN.
    assign w_sample   = ((r_state == S_SHIFT) && (r_bitcnt != '0)) || (r_state == S_DRAIN);
    assign w_acc_next = r_acc + {{(CNT_W-1){1'b0}}, det_op};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_bitcnt == C_LAST_BIT) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; done reuses the grant held through DONE
    always_comb begin
        busy    = (r_state != S_IDLE);
        det_rst = (r_state == S_FLUSH);
        det_ip  = (r_state == S_SHIFT) ? r_sreg[DATA_W-1] : 1'b0;
        done    = (r_state == S_DONE) ? r_gnt : '0;
    end

    // Job datapath: grant/latch, shift, count, publish result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last   <= C_LAST_INIT;
            r_gnt    <= '0;
            r_sreg   <= '0;
            r_bitcnt <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_last       <= w_win;
                        r_gnt        <= '0;
                        r_gnt[w_win] <= 1'b1;
                        r_sreg       <= data[w_win*DATA_W +: DATA_W];
                    end
                end
                S_FLUSH: begin
                    r_bitcnt <= '0;
                    r_acc    <= '0;
                end
                S_SHIFT: begin
                    r_sreg   <= r_sreg << 1;
                    r_bitcnt <= r_bitcnt + CNT_W'(1);
                    if (w_sample) r_acc <= w_acc_next;
                end
                S_DRAIN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_acc_next;
                end
                S_DONE: begin
                    r_gnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign gnt = r_gnt;
    assign cnt = r_cnt;

`ifdef SEQ_DET_SCHED_PROT_EN
    logic r_prev_op;
    logic r_err;

    // Flag two consecutive sampled detector pulses; sticky until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_op <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_prev_op <= w_sample & det_op;
            if (w_sample && det_op && r_prev_op) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler sharing one serial sequence detector among `N_REQ` requesters. Each requester submits a `DATA_W`-bit word. The block grants one requester and flushes the detector. It then serializes the word MSB-first onto the detector input and counts detector output pulses. Finally it returns the count with a one-cycle done pulse. The block sits between requester logic and the detector's `ip`/`op`/`rst` pins.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `DATA_W`, 8, word width serialized per job
- `CNT_W`, $clog2(DATA_W+1), width of detection count
- `clk`  in  1  clock, all logic on posedge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester job request, level
- `data`  in  N_REQ*DATA_W  word for requester i at `[i*DATA_W +: DATA_W]`
- `gnt`  out  N_REQ  one-hot grant, held for the whole job
- `done`  out  N_REQ  one-cycle completion pulse to granted requester
- `cnt`  out  CNT_W  detections in last job; valid from the `done` cycle, held until the next `done`
- `busy`  out  1  high in every state except IDLE
- `det_rst`  out  1  active-high one-cycle detector flush
- `det_ip`  out  1  serial bit to detector `ip`
- `det_op`  in  1  detector `op`, registered, one-cycle pulse
- `err`  out  1  sticky protocol error (see Configuration)

## Operation
- States: IDLE, FLUSH, SHIFT, DRAIN, DONE.
- IDLE:
  - If any `req` bit is high, pick the winner by round-robin, searching from `last+1` mod N_REQ.
  - Latch the winner's `data` into the shift register and set `last` = winner.
  - Register the one-hot `gnt` and go to FLUSH.
- FLUSH: `det_rst`=1, `det_ip`=0, clear the bit counter and the count accumulator. Go to SHIFT.
- SHIFT: `det_ip` = shift-register MSB; shift left by 1. Stay DATA_W cycles, then go to DRAIN.
- DRAIN: `det_ip`=0. Go to DONE.
- DONE: `done[winner]`=1 and `cnt` updated with the accumulator. Go to IDLE; `gnt` clears on the exit edge.
- Detector contract: `op` for the bit driven in cycle k appears in cycle k+1.
- Sampling window: `det_op` is counted from the 2nd SHIFT cycle through DRAIN, exactly DATA_W cycles. `det_op` in FLUSH, the first SHIFT cycle, DONE or IDLE is ignored.
- Accumulator is CNT_W wide and cannot overflow (maximum DATA_W).
- Dropping `req` mid-job does not abort the job; `done` still pulses. A `req` still high at DONE re-enters arbitration at lowest priority.
- `data` is sampled only in the IDLE grant cycle; later changes are ignored.

## Timing
- Reset values:
  - `gnt`=0, `done`=0, `cnt`=0, `busy`=0, `det_rst`=0, `det_ip`=0, `err`=0.
  - state IDLE.
  - `last`=N_REQ-1, so requester 0 has first priority.
- Reset asserted in any state: all outputs and state return to reset values immediately, and the job is lost with no `done`.
- Job latency with `req` seen in IDLE at cycle 0 (DATA_W=8):
  - FLUSH and `gnt` high at cycle 1.
  - SHIFT at cycles 2–9.
  - DRAIN at cycle 10.
  - DONE (`done` pulse, `cnt` valid) at cycle 11.
  - IDLE at cycle 12.
- General: `done` comes DATA_W+3 cycles after the arbitration cycle.
- Back-to-back throughput: one job per DATA_W+4 cycles, since there is always one IDLE cycle between jobs.
- `busy` is high in cycles 1–11.

## Configuration
- `SEQ_DET_SCHED_PROT_EN` defined:
  - During the sampling window, `det_op` high in two consecutive sampled cycles sets `err`.
  - `err` stays high until reset.
  - Counting is unaffected; both pulses are counted.
- Not defined: `err` tied to 0 and no checker logic is synthesized.

## Test plan
- Reset: hold `rst`=0 with random `req`/`det_op` → all outputs 0; after release with `req`=4'b0010 → `gnt`=4'b0010 at cycle 1.
- Single job: `req[0]`, `data[7:0]`=8'hB6, `det_op` pulsed cycles 4 and 7 →
  - `det_rst` high at cycle 1.
  - `det_ip` = 1,0,1,1,0,1,1,0 over cycles 2–9.
  - `done`=4'b0001 and `cnt`=2 at cycle 11.
- Fairness: `req`=4'b1111 held → grants 0,1,2,3,0 with `gnt` rising edges 12 cycles apart.
- Ignored window: `det_op` high at cycles 1, 2 and 11 only → `cnt`=0.
- Mid-job reset: `rst` low at cycle 5 of a req2 job → outputs 0 at once and no `done`; after release, `req`=4'b0110 → req1 granted first.
- Protocol: `det_op` high at cycles 5 and 6 → `cnt`=2; `err`=1 and sticky with macro defined, `err`=0 without.
